// File: rtl/order_25d_merge_if.sv
// Handshake bundle for order_25d_merge: 25-word frame input channel and merged-word output channel.
// The master modport is the environment; the slave modport is the merge block.
interface order_25d_merge_if #(
   parameter int DSIZE = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [DSIZE-1:0] id00, id01, id02, id03, id04, id05, id06, id07, id08, id09,
                     id10, id11, id12, id13, id14, id15, id16, id17, id18, id19,
                     id20, id21, id22, id23, id24;
   logic [DSIZE-1:0] od;
   logic             out_valid;
   logic             out_ready;
   logic [4:0]       out_idx;
   logic             out_last;

   modport master (
      output in_valid, out_ready,
      output id00, id01, id02, id03, id04, id05, id06, id07, id08, id09,
             id10, id11, id12, id13, id14, id15, id16, id17, id18, id19,
             id20, id21, id22, id23, id24,
      input  in_ready, od, out_valid, out_idx, out_last
   );

   modport slave (
      input  in_valid, out_ready,
      input  id00, id01, id02, id03, id04, id05, id06, id07, id08, id09,
             id10, id11, id12, id13, id14, id15, id16, id17, id18, id19,
             id20, id21, id22, id23, id24,
      output in_ready, od, out_valid, out_idx, out_last
   );
endinterface

// File: rtl/order_25d_merge.sv
// Merges six ascending 4-word groups plus one singleton into a 25-beat ranked stream.
// Define ORDER_25D_MEDIAN_EN to emit only the rank-12 beat (median) instead of the full stream.
module order_25d_merge #(
   parameter int DSIZE = 8
) (
   input logic            clock,
   input logic            rst,
   order_25d_merge_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] MERGE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [2:0] SEL_SINGLE = 3'd6;
   localparam logic [2:0] SEL_NONE   = 3'd7;

   logic [1:0]                  state_q, state_d;
   logic [5:0][3:0][DSIZE-1:0]  grp_q;
   logic [DSIZE-1:0]            single_q;
   logic [5:0][2:0]             ptr_q, ptr_d;
   logic                        single_done_q, single_done_d;
   logic [4:0]                  rank_q, rank_d;
   logic [DSIZE-1:0]            od_q, od_d;
   logic [4:0]                  idx_q, idx_d;
   logic                        last_q, last_d;
   logic                        valid_q, valid_d;

   logic [24:0][DSIZE-1:0]      frame_in;
   logic                        capture;
   logic                        load;
   logic                        best_found;
   logic [DSIZE-1:0]            best_val;
   logic [2:0]                  best_sel;

   assign frame_in = {bus.id24, bus.id23, bus.id22, bus.id21, bus.id20,
                      bus.id19, bus.id18, bus.id17, bus.id16, bus.id15,
                      bus.id14, bus.id13, bus.id12, bus.id11, bus.id10,
                      bus.id09, bus.id08, bus.id07, bus.id06, bus.id05,
                      bus.id04, bus.id03, bus.id02, bus.id01, bus.id00};

   assign capture = (state_q == IDLE) && bus.in_valid && !rst;
   assign load    = (state_q == MERGE) && (!valid_q || bus.out_ready);

   // NOTE: frame storage carries no reset; capture rewrites every word before any is read.
   always_ff @(posedge clock) begin
      if (capture) begin
         grp_q    <= frame_in[23:0];
         single_q <= frame_in[24];
      end
   end

   // Strict less-than keeps the lowest group on ties; the singleton only wins when strictly smaller.
   always_comb begin
      best_found = 1'b0;
      best_val   = '0;
      best_sel   = SEL_NONE;
      for (int g = 0; g < 6; g++) begin
         if (ptr_q[g] != 3'd4 &&
             (!best_found || grp_q[g][ptr_q[g][1:0]] < best_val)) begin
            best_found = 1'b1;
            best_val   = grp_q[g][ptr_q[g][1:0]];
            best_sel   = 3'(g);
         end
      end
      if (!single_done_q && (!best_found || single_q < best_val)) begin
         best_found = 1'b1;
         best_val   = single_q;
         best_sel   = SEL_SINGLE;
      end
   end

   // NOTE: every next-state signal takes its hold value first, so no path through the case infers a latch.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      single_done_d = single_done_q;
      rank_d        = rank_q;
      od_d          = od_q;
      idx_d         = idx_q;
      last_d        = last_q;
      valid_d       = valid_q;
      case (state_q)
         IDLE: begin
            if (capture) begin
               state_d       = MERGE;
               ptr_d         = '0;
               single_done_d = 1'b0;
               rank_d        = '0;
            end
         end
         MERGE: begin
            if (load) begin
               if (best_sel == SEL_SINGLE) begin
                  single_done_d = 1'b1;
               end else if (best_sel != SEL_NONE) begin
                  ptr_d[best_sel] = ptr_q[best_sel] + 3'd1;
               end
               rank_d = rank_q + 5'd1;
`ifdef ORDER_25D_MEDIAN_EN
               // Lower ranks are consumed silently; only the median becomes visible.
               if (rank_q == 5'd12) begin
                  valid_d = 1'b1;
                  od_d    = best_val;
                  idx_d   = rank_q;
                  last_d  = 1'b1;
                  state_d = DRAIN;
               end
`else
               valid_d = 1'b1;
               od_d    = best_val;
               idx_d   = rank_q;
               last_d  = (rank_q == 5'd24);
               if (rank_q == 5'd24) begin
                  state_d = DRAIN;
               end
`endif
            end
         end
         DRAIN: begin
            if (bus.out_ready) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         single_done_q <= 1'b0;
         rank_q        <= '0;
         od_q          <= '0;
         idx_q         <= '0;
         last_q        <= 1'b0;
         valid_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         single_done_q <= single_done_d;
         rank_q        <= rank_d;
         od_q          <= od_d;
         idx_q         <= idx_d;
         last_q        <= last_d;
         valid_q       <= valid_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.od        = od_q;
   assign bus.out_idx   = idx_q;
   assign bus.out_last  = last_q;
   assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_order_25d_merge.sv
// Self-checking bench for order_25d_merge: table vectors, hand-written corner sequences,
// and random frames checked against a queue-based head-merge reference model.
module tb_order_25d_merge;
   typedef logic [24:0][7:0] frame_t;

   typedef struct packed {
      frame_t     stim;
      frame_t     exp;
      logic [1:0] rdy_mode;
   } vec_t;

`ifdef ORDER_25D_MEDIAN_EN
   localparam int NBEATS    = 1;
   localparam int FIRST_LAT = 13;
`else
   localparam int NBEATS    = 25;
   localparam int FIRST_LAT = 1;
`endif

   logic clock;
   logic rst;
   int   checks;
   int   failures;

   order_25d_merge_if #(.DSIZE(8)) bus ();

   order_25d_merge #(.DSIZE(8)) dut (
      .clock (clock),
      .rst   (rst),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_frame(input frame_t f);
      bus.id00 = f[0];  bus.id01 = f[1];  bus.id02 = f[2];  bus.id03 = f[3];  bus.id04 = f[4];
      bus.id05 = f[5];  bus.id06 = f[6];  bus.id07 = f[7];  bus.id08 = f[8];  bus.id09 = f[9];
      bus.id10 = f[10]; bus.id11 = f[11]; bus.id12 = f[12]; bus.id13 = f[13]; bus.id14 = f[14];
      bus.id15 = f[15]; bus.id16 = f[16]; bus.id17 = f[17]; bus.id18 = f[18]; bus.id19 = f[19];
      bus.id20 = f[20]; bus.id21 = f[21]; bus.id22 = f[22]; bus.id23 = f[23]; bus.id24 = f[24];
   endtask

   // Reference: repeatedly pop the smallest front among seven queues, first queue wins ties.
   function automatic frame_t model(input frame_t f);
      logic [7:0] q [7][$];
      frame_t     r;
      for (int g = 0; g < 6; g++)
         for (int e = 0; e < 4; e++)
            q[g].push_back(f[4*g+e]);
      q[6].push_back(f[24]);
      for (int k = 0; k < 25; k++) begin
         int w;
         w = -1;
         for (int j = 0; j < 7; j++)
            if (q[j].size() > 0 && (w < 0 || q[j][0] < q[w][0])) w = j;
         r[k] = q[w].pop_front();
      end
      return r;
   endfunction

   function automatic logic rdy(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
         default: return $urandom_range(0, 3) != 0;
      endcase
   endfunction

   task automatic start_frame(input frame_t f, input string name);
      int w;
      w = 0;
      while (!bus.in_ready && w < 100) begin
         step();
         w++;
      end
      check({name, "_idle"}, 32'(bus.in_ready), 32'd1);
      set_frame(f);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check({name, "_cap"}, 32'(bus.in_ready), 32'd0);
   endtask

   // Entered in the cycle right after the capture edge; consumes the whole frame.
   task automatic collect_frame(input frame_t exp, input int mode, input string name);
      int n, cyc;
      bit seen, done;
      n = 0; cyc = 0; seen = 1'b0; done = 1'b0;
      while (!done && cyc < 500) begin
         bus.out_ready = rdy(mode, cyc);
         if (bus.out_valid) begin
            if (!seen) begin
               check({name, "_lat"}, 32'(cyc), 32'(FIRST_LAT));
               seen = 1'b1;
            end
`ifdef ORDER_25D_MEDIAN_EN
            check($sformatf("%s_od%0d", name, n), 32'(bus.od), 32'(exp[12]));
            check($sformatf("%s_idx%0d", name, n), 32'(bus.out_idx), 32'd12);
            check($sformatf("%s_last%0d", name, n), 32'(bus.out_last), 32'd1);
`else
            check($sformatf("%s_od%0d", name, n), 32'(bus.od), 32'(exp[n]));
            check($sformatf("%s_idx%0d", name, n), 32'(bus.out_idx), 32'(n));
            check($sformatf("%s_last%0d", name, n), 32'(bus.out_last), 32'(n == 24));
`endif
            if (bus.out_ready) begin
               n++;
               done = (n == NBEATS);
            end
         end
         step();
         cyc++;
      end
      check({name, "_beats"}, 32'(n), 32'(NBEATS));
      check({name, "_vld_after"}, 32'(bus.out_valid), 32'd0);
      check({name, "_rdy_after"}, 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;
   endtask

   initial begin
      int     asc_vals [25] = '{1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15,
                                4, 8, 12, 16, 17, 18, 19, 20, 21, 22, 23, 24, 0};
      frame_t asc, sorted, sevens, fb;
      vec_t   vecs [4];
      int     extra;

      checks = 0;
      failures = 0;
      for (int i = 0; i < 25; i++) begin
         asc[i]    = asc_vals[i][7:0];
         sorted[i] = 8'(i);
         sevens[i] = 8'd7;
         fb[i]     = 8'(24 - i);
      end
      vecs[0] = '{stim: asc,    exp: sorted, rdy_mode: 2'd0};
      vecs[1] = '{stim: sevens, exp: sevens, rdy_mode: 2'd0};
      vecs[2] = '{stim: asc,    exp: sorted, rdy_mode: 2'd1};
      vecs[3] = '{stim: asc,    exp: sorted, rdy_mode: 2'd2};

      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      set_frame(asc);
      step();
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_last", 32'(bus.out_last), 32'd0);
      check("rst_idx", 32'(bus.out_idx), 32'd0);
      check("rst_od", 32'(bus.od), 32'd0);
      check("rst_ready", 32'(bus.in_ready), 32'd1);
      rst = 1'b0;
      step();

      for (int i = 0; i < 4; i++) begin
         start_frame(vecs[i].stim, $sformatf("vec%0d", i));
         collect_frame(vecs[i].exp, int'(vecs[i].rdy_mode), $sformatf("vec%0d", i));
      end

      // Reset wins over a simultaneous offer.
      rst = 1'b1;
      bus.in_valid = 1'b1;
      step();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check("rstpri_ready", 32'(bus.in_ready), 32'd1);
      step();
      check("rstpri_ready2", 32'(bus.in_ready), 32'd1);
      check("rstpri_valid", 32'(bus.out_valid), 32'd0);

      // Reset in the middle of a frame discards it.
      start_frame(asc, "midrst");
      for (int i = 0; i < 11; i++) step();
`ifdef ORDER_25D_MEDIAN_EN
      check("midrst_pre_valid", 32'(bus.out_valid), 32'd0);
`else
      check("midrst_pre_idx", 32'(bus.out_idx), 32'd10);
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_idx", 32'(bus.out_idx), 32'd0);
      extra = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus.out_valid) extra++;
      end
      check("midrst_no_beats", 32'(extra), 32'd0);
      start_frame(asc, "postrst");
      collect_frame(sorted, 0, "postrst");

      // in_valid held high: the second frame is taken only once the first has drained.
      set_frame(asc);
      bus.in_valid = 1'b1;
      step();
      check("cont_a_cap", 32'(bus.in_ready), 32'd0);
      set_frame(fb);
      collect_frame(sorted, 0, "cont_a");
      step();
      check("cont_b_cap", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b0;
      collect_frame(model(fb), 0, "cont_b");

      for (int fr = 0; fr < 20; fr++) begin
         frame_t f;
         for (int i = 0; i < 25; i++)
            f[i] = 8'($urandom_range(0, (fr < 10) ? 15 : 255));
         if (fr % 2 == 0) begin
            for (int g = 0; g < 6; g++)
               for (int a = 0; a < 3; a++)
                  for (int b = 4*g; b < 4*g + 3 - a; b++)
                     if (f[b] > f[b+1]) begin
                        logic [7:0] t;
                        t = f[b]; f[b] = f[b+1]; f[b+1] = t;
                     end
         end
         start_frame(f, $sformatf("rnd%0d", fr));
         collect_frame(model(f), 2, $sformatf("rnd%0d", fr));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/order_25d_merge.md
ORDER_25D_MERGE -- requirements
Module: order_25d_merge

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width in bits.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  frame offered on id00..id24.
REQ-005 SHALL have port in_ready  output  1  block accepts a frame this cycle.
REQ-006 SHALL have ports id00..id24  input  DSIZE each  frame: six ascending groups {id00-03},{id04-07},...,{id20-23} plus singleton id24.
REQ-007 SHALL have port od  output  DSIZE  merged output word.
REQ-008 SHALL have port out_valid  output  1  od/out_idx/out_last valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-010 SHALL have port out_idx  output  5  rank of od within frame, 0 = smallest.
REQ-011 SHALL have port out_last  output  1  final beat of frame.

Function
REQ-012 SHALL capture all 25 inputs into internal registers on the edge where in_valid && in_ready.
REQ-013 SHALL implement states IDLE (in_ready=1), MERGE (in_ready=0), DRAIN (in_ready=0); IDLE->MERGE on capture, MERGE->DRAIN when final beat is loaded into output register, DRAIN->IDLE when final beat accepted.
REQ-014 SHALL, in MERGE, load the output register whenever !out_valid || out_ready, with the minimum of the seven current heads (six group heads, singleton), unsigned comparison.
REQ-015 SHALL break ties by lowest group index, singleton last, and advance only the winning head pointer (group pointer 0..4, exhausted at 4; singleton flag).
REQ-016 SHALL assert out_valid for rank 0 on the edge after capture edge (capture edge k -> out_valid high after edge k+1), then sustain one beat per cycle while out_ready=1.
REQ-017 SHALL hold od, out_idx, out_last, out_valid stable while out_valid && !out_ready.
REQ-018 SHALL emit ranks 0..24 in order, out_last=1 only with out_idx=24.
REQ-019 SHALL assert in_ready the cycle after the last beat is accepted; in_valid while in_ready=0 is ignored and not queued.
REQ-020 SHALL, for groups not ascending, still output deterministic head-merge result per REQ-014/015 (not guaranteed sorted); no error flag.
REQ-021 SHALL produce exactly 25 beats per frame in full mode regardless of data duplicates.

Reset
REQ-022 SHALL, on rst=1 at an edge, go to IDLE, clear pointers and rank counter, out_valid=0, out_last=0, out_idx=0, od=0, in_ready=1 from next cycle.
REQ-023 SHALL, on rst mid-frame, discard the frame entirely; no further beats of it appear.
REQ-024 SHALL give rst priority over simultaneous in_valid (frame not captured).

Configuration
REQ-025 SHALL, with macro ORDER_25D_MEDIAN_EN defined, suppress out_valid for ranks 0..11 and emit one beat: rank 12, out_idx=12, out_last=1, then go to DRAIN; first (only) out_valid high after edge k+13.
REQ-026 SHALL, without ORDER_25D_MEDIAN_EN, stream all 25 ranks per REQ-016..018.

Verification
REQ-027 SHALL cover: groups {1,5,9,13},{2,6,10,14},{3,7,11,15},{4,8,12,16},{17,18,19,20},{21,22,23,24}, id24=0, out_ready=1 -> od 0,1,2,...,24 on 25 consecutive cycles, out_last with 24.
REQ-028 SHALL cover: all inputs 7 -> 25 beats od=7, out_idx 0..24; ties consume groups 0..5 then singleton.
REQ-029 SHALL cover: out_ready toggling 1,0,0,1 repeating -> no beat lost or duplicated, outputs stable during stalls, same sequence as REQ-027.
REQ-030 SHALL cover: rst pulsed at output rank 10 -> out_valid=0 next cycle, in_ready=1, new frame then starts at rank 0.
REQ-031 SHALL cover: in_valid held high continuously -> second frame captured only the cycle after first frame's out_last beat accepted.
REQ-032 SHALL cover (ORDER_25D_MEDIAN_EN): REQ-027 stimulus -> single beat od=12, out_idx=12, out_last=1, 13 cycles after capture.
